// File: rtl/tiny_accumulator.sv
// tiny_accumulator: debounced-button hex accumulator with add/subtract, a sticky
// carry/borrow flag and a multi-digit 7-segment display of the running value.
module tiny_accumulator #(
    parameter int DIGITS          = 2,
    parameter int IN_W            = 4,
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [IN_W-1:0]     OPERAND,
    input  logic                EXEC_BTN,
    input  logic                CLR_BTN,
    input  logic                SUB,
    output logic [7*DIGITS-1:0] SEG,
    output logic                LED,
    output logic                OVF
);
    localparam int ACC_W  = 4 * DIGITS;
    localparam int SYNC_W = IN_W + 3;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int BTN_EXEC = 0;
    localparam int BTN_CLR  = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h67;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [SYNC_W-1:0]     sync1_d, sync1_q;
    logic [SYNC_W-1:0]     sync2_d, sync2_q;
    logic [IN_W-1:0]       opnd_s;
    logic                  sub_s;
    logic [1:0]            btn_s;
    logic [1:0][CNT_W-1:0] cnt_d, cnt_q;
    logic [1:0]            lvl_d, lvl_q;
    logic [1:0]            pulse_d, pulse_q;
    logic                  exec_p, clr_p;
    state_t                state_d, state_q;
    logic [ACC_W-1:0]      acc_d, acc_q;
    logic                  ovf_d, ovf_q;
    logic [ACC_W:0]        opnd_ext, add_full, sub_full;

    // Two-flop synchroniser for every asynchronous input.
    always_comb begin
        sync1_d = {SUB, CLR_BTN, EXEC_BTN, OPERAND};
        sync2_d = sync1_q;
    end

    always_comb begin
        opnd_s           = sync2_q[IN_W-1:0];
        btn_s[BTN_EXEC]  = sync2_q[IN_W];
        btn_s[BTN_CLR]   = sync2_q[IN_W+1];
        sub_s            = sync2_q[IN_W+2];
    end

    // Accepted level flips only after DEBOUNCE_CYCLES consecutive differing
    // cycles; the registered pulse marks a 0->1 acceptance.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = '0;
            if (btn_s[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            pulse_d[i] = lvl_d[i] & ~lvl_q[i];
        end
    end

    always_comb begin
        exec_p = pulse_q[BTN_EXEC];
        clr_p  = pulse_q[BTN_CLR];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            lvl_q   <= '0;
            pulse_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear wins over a coincident execute.
    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = ST_EMPTY;
        end else if (exec_p) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        LED = (state_q == ST_RUN);
        OVF = ovf_q;
    end

    // One extra bit on the operands exposes carry-out and borrow directly.
    always_comb begin
        opnd_ext            = '0;
        opnd_ext[IN_W-1:0]  = opnd_s;
        add_full            = {1'b0, acc_q} + opnd_ext;
        sub_full            = {1'b0, acc_q} - opnd_ext;
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_p) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (exec_p) begin
            if (state_q == ST_EMPTY) begin
                acc_d = opnd_ext[ACC_W-1:0];
                ovf_d = 1'b0;
            end else if (sub_s) begin
                acc_d = sub_full[ACC_W-1:0];
                ovf_d = ovf_q | sub_full[ACC_W];
            end else begin
                acc_d = add_full[ACC_W-1:0];
                ovf_d = ovf_q | add_full[ACC_W];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        SEG = '0;
        for (int k = 0; k < DIGITS; k++) begin
            SEG[7*k +: 7] = hex_to_seg(acc_q[4*k +: 4]);
        end
    end

endmodule
